// File: rtl/shift_add_mult_if.sv
// Operand/result bundle between the issuing unit and the shift-add MUL/MAC unit.
interface shift_add_mult_if #(
  parameter int WIDTH = 16
);
  logic                 start;
  logic                 mac;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, mac, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, mac, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/shift_add_mult.sv
// Sequential shift-add multiplier / multiply-accumulator, one add+shift per cycle.
// Optional two's-complement operands when SHIFT_ADD_MULT_SIGNED_EN is defined.
module shift_add_mult #(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  shift_add_mult_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                 state_reg, state_next;
  logic [2*WIDTH:0]       acc_reg, acc_next;
  logic [WIDTH-1:0]       mcand_reg, mcand_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic                   mac_reg, mac_next;
  logic                   done_reg, done_next;
  logic [2*WIDTH-1:0]     product_reg, product_next;

  logic [WIDTH:0]         upper_sum;
  logic [2*WIDTH:0]       acc_step;
  logic                   last_step;
  logic [WIDTH-1:0]       a_load;
  logic [WIDTH-1:0]       b_load;
  logic [2*WIDTH-1:0]     result;

  // Upper half carries one extra bit so the add never overflows before the shift.
  assign upper_sum = acc_reg[0] ? (acc_reg[2*WIDTH:WIDTH] + {1'b0, mcand_reg})
                                : acc_reg[2*WIDTH:WIDTH];
  assign acc_step  = {upper_sum, acc_reg[WIDTH-1:0]} >> 1;
  assign last_step = (cnt_reg == CNT_W'(WIDTH - 1));

`ifdef SHIFT_ADD_MULT_SIGNED_EN
  logic sign_reg, sign_next;

  // Magnitudes are N-bit unsigned, so the most negative input maps to 2^(N-1).
  assign a_load = bus.a[WIDTH-1] ? (-bus.a) : bus.a;
  assign b_load = bus.b[WIDTH-1] ? (-bus.b) : bus.b;
  assign result = sign_reg ? (-acc_step[2*WIDTH-1:0]) : acc_step[2*WIDTH-1:0];

  always_comb begin
    sign_next = sign_reg;
    if (state_reg == IDLE && bus.start) begin
      sign_next = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_reg <= 1'b0;
    end else begin
      sign_reg <= sign_next;
    end
  end
`else
  assign a_load = bus.a;
  assign b_load = bus.b;
  assign result = acc_step[2*WIDTH-1:0];
`endif

  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    mcand_next   = mcand_reg;
    cnt_next     = cnt_reg;
    mac_next     = mac_reg;
    done_next    = 1'b0;
    product_next = product_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          mcand_next = a_load;
          acc_next   = {{(WIDTH + 1){1'b0}}, b_load};
          cnt_next   = '0;
          mac_next   = bus.mac;
          state_next = RUN;
        end
      end
      RUN: begin
        acc_next = acc_step;
        cnt_next = cnt_reg + CNT_W'(1);
        if (last_step) begin
          state_next   = IDLE;
          done_next    = 1'b1;
          product_next = mac_reg ? (product_reg + result) : result;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      mcand_reg   <= '0;
      cnt_reg     <= '0;
      mac_reg     <= 1'b0;
      done_reg    <= 1'b0;
      product_reg <= '0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      mcand_reg   <= mcand_next;
      cnt_reg     <= cnt_next;
      mac_reg     <= mac_next;
      done_reg    <= done_next;
      product_reg <= product_next;
    end
  end

  assign bus.busy    = (state_reg == RUN);
  assign bus.done    = done_reg;
  assign bus.product = product_reg;
endmodule

// File: tb/tb_shift_add_mult.sv
// Directed-vector bench for shift_add_mult (WIDTH=16), unsigned or signed build.
module tb_shift_add_mult;
  localparam int W = 16;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   n;
  int   dones;

  shift_add_mult_if #(.WIDTH(W)) bus ();

  shift_add_mult #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Caller is positioned at a negedge; start is raised in that same cycle.
  task automatic mult(input logic [W-1:0] a, input logic [W-1:0] b, input logic mac,
                      input logic [2*W-1:0] exp, input string tag);
    bus.a = a; bus.b = b; bus.mac = mac; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_busy"}, 64'(bus.busy), 64'd1);
    n = 1;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'd17);
    check(tag, 64'(bus.product), 64'(exp));
  endtask

  initial begin
    total = 0; bad = 0;
    bus.start = 1'b0; bus.mac = 1'b0; bus.a = '0; bus.b = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_prod", 64'(bus.product), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    mult(16'd3, 16'd5, 1'b0, 32'h0000000F, "m3x5");
    @(negedge clk);
    check("done_low", 64'(bus.done), 64'd0);

`ifdef SHIFT_ADD_MULT_SIGNED_EN
    mult(16'hFFFF, 16'hFFFF, 1'b0, 32'h00000001, "mffff");
    mult(16'h8000, 16'd2,    1'b0, 32'hFFFF0000, "m8000x2");
    mult(16'hFFFD, 16'd5,    1'b0, 32'hFFFFFFF1, "mneg3x5");
    mult(16'h8000, 16'h8000, 1'b0, 32'h40000000, "mminxmin");
`else
    mult(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "mffff");
    mult(16'h8000, 16'd2,    1'b0, 32'h00010000, "m8000x2");
    mult(16'hFFFD, 16'd5,    1'b0, 32'h0004FFF1, "mfffdx5");
    mult(16'h8000, 16'h8000, 1'b0, 32'h40000000, "m8000sq");
`endif

    // Back-to-back: each start raised in the cycle done is high.
    @(negedge clk);
    mult(16'd3, 16'd5, 1'b0, 32'd15, "mac_a");
    mult(16'd2, 16'd2, 1'b1, 32'd19, "mac_b");
`ifdef SHIFT_ADD_MULT_SIGNED_EN
    mult(16'hFFFF, 16'hFFFF, 1'b0, 32'h00000001, "wrap_a");
    mult(16'd2,    16'hFFFF, 1'b1, 32'hFFFFFFFF, "wrap_b");
    mult(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000000, "wrap_c");
`else
    mult(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "wrap_a");
    mult(16'd2,    16'hFFFF, 1'b1, 32'hFFFFFFFF, "wrap_b");
    mult(16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE0000, "wrap_c");
`endif

    // Start while busy is ignored; operands change mid-run.
    @(negedge clk);
    bus.a = 16'd7; bus.b = 16'd9; bus.mac = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.a = 16'd1; bus.b = 16'd1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 6; dones = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("busy_ign_lat", 64'(n), 64'd17);
    check("busy_ign_prod", 64'(bus.product), 64'd63);
    repeat (20) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    check("busy_ign_quiet", 64'(dones), 64'd0);

    // Asynchronous reset mid-run, between clock edges.
    bus.a = 16'd7; bus.b = 16'd9; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_done", 64'(bus.done), 64'd0);
    check("arst_prod", 64'(bus.product), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    check("arst_quiet", 64'(dones), 64'd0);

    // First op after reset with mac=1 accumulates onto zero; zero operands keep full latency.
    mult(16'd4, 16'd4,    1'b1, 32'd16, "post_rst_mac");
    mult(16'd0, 16'd1234, 1'b1, 32'd16, "a0_mac");
    mult(16'd77, 16'd0,   1'b0, 32'd0,  "b0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shift_add_mult.md
Name: shift_add_mult

Overview:
- Parametrised sequential shift-add multiplier. Integrates the product accumulator, operand registers and control FSM in one block.
- Successor to the fixed 16-bit accumulator plus external controller pair. Each step does a combined conditional add and right shift in a single cycle.
- Adds a start/busy/done handshake, an optional multiply-accumulate mode, and optional signed operation.
- Sits beside the ALU as the multicycle MUL/MAC unit.

Parameters:
- WIDTH, 16, operand width N in bits; product is 2N bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), step counter width (localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- mac  input  1  sampled with start: 1 = add the new product to the previous product.
- a  input  WIDTH  multiplicand; captured when start is accepted.
- b  input  WIDTH  multiplier; captured when start is accepted.
- busy  output  1  high while the FSM is in RUN.
- done  output  1  one-cycle pulse when the product is updated.
- product  output  2*WIDTH  registered result; held until the next completion.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state = IDLE.
  - busy = 0, done = 0, product = 0.
  - Internal accumulator, multiplicand register, counter and mac flag all cleared.
  - Any in-flight operation is discarded with no done pulse.
- Internal registers:
  - acc: 2N+1 bits; upper N+1 bits hold the partial sum including the carry bit.
  - mcand: N bits.
  - cnt: CNT_W bits.
  - mac_q: 1 bit.
- IDLE:
  - start=1 at edge E0: mcand<=a; acc<={(N+1)'b0, b}; cnt<=0; mac_q<=mac; state->RUN.
  - start=0: hold all state.
  - done is deasserted on any edge where no completion occurs.
- RUN, each edge:
  - If acc[0]=1: upper = acc[2N:N] + {1'b0, mcand}. Otherwise upper = acc[2N:N].
  - acc <= {upper, acc[N-1:0]} >> 1 (logical; the carry bit enters bit 2N-1).
  - cnt <= cnt+1.
- Completion:
  - On the edge where cnt reaches N-1 (the Nth RUN edge, E_N), state returns to IDLE and done<=1 for exactly one cycle.
  - product <= final acc[2N-1:0] when mac_q=0.
  - product <= product + final acc[2N-1:0] when mac_q=1; the sum is modulo 2^(2N) and overflow is silently discarded.
- Latency and throughput:
  - start sampled at E0, done and product visible after E_N: N+1 edges total.
  - A new operation may start every N+1 cycles.
- busy = (state==RUN), decoded from registered state.
- Boundary conditions:
  - start while busy: ignored; no queueing.
  - start in the same cycle as done=1: accepted, because the FSM is already in IDLE.
  - b=0 or a=0: still runs the full N steps; result is 0 (or unchanged product when mac=1).
  - a and b may change freely during RUN with no effect on the operation.
  - mac=1 as the first operation after reset: accumulates onto 0.

Optional Feature:
- Macro: SHIFT_ADD_MULT_SIGNED_EN.
- When defined, a and b are two's complement:
  - At load, mcand and the low half of acc take |a| and |b| as N-bit unsigned magnitudes. The most negative value maps to 2^(N-1), which fits.
  - A sign flag = a[N-1]^b[N-1] is registered at load.
  - At completion the 2N-bit magnitude is negated if the sign flag is set, before the optional MAC addition.
  - Latency is unchanged.
- When not defined: all operands are unsigned, no sign logic is synthesised, and the behaviour is exactly as above.

Test Plan:
- WIDTH=16, a=3, b=5, mac=0, start one cycle -> busy high for 16 cycles; done pulses once after the 17th edge counted from the start edge; product=32'h0000000F; done low the following cycle.
- a=16'hFFFF, b=16'hFFFF -> product=32'hFFFE0001. Then a=16'h8000, b=2 -> product=32'h00010000.
- a=3, b=5, mac=0; then a=2, b=2, mac=1 issued in the cycle done is high -> second done shows product=19. Then mac=1 with a=b=16'hFFFF on product=32'hFFFFFFFF -> product wraps to 32'hFFFE0000.
- Start a=7, b=9; pulse start again with a=1, b=1 at cycle 5 of RUN -> second start ignored; single done with product=63.
- Assert rst at cycle 8 of RUN -> busy, done and product go 0 immediately with no clock edge; no done pulse follows; a fresh 4*4 run then gives 16.
- SHIFT_ADD_MULT_SIGNED_EN defined: a=16'hFFFD (-3), b=5 -> product=32'hFFFFFFF1. a=16'h8000, b=16'h8000 -> product=32'h40000000. Undefined: a=16'hFFFD, b=5 -> product=32'h0004FFF1.
